// File: rtl/user_session_monitor_pkg.sv
// Shared definitions for the memory-tester session monitor: user ID sizing,
// FSM state encoding and the user-ID to lockout-bit mapping.
package user_session_monitor_pkg;

    localparam int USER_ID_W = 3;
    localparam int NUM_USERS = 7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_LOGOUT = 2'd2;

    // User k owns bit k-1 of the lockout bitmap; ID 0 means "no user".
    function automatic logic [USER_ID_W-1:0] id_to_bit(input logic [USER_ID_W-1:0] id);
        return id - USER_ID_W'(1);
    endfunction

endpackage

// File: rtl/session_timeout_counter.sv
// Loadable, saturating cycle counter with a terminal-count flag that fires
// one cycle before saturation, so a registered reaction lands on LIMIT.
module session_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] TC_VAL  = CW'(LIMIT - 1);
    localparam logic [CW-1:0] SAT_VAL = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != SAT_VAL)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/user_session_monitor.sv
// Session monitor: tracks the active login, forces logout on inactivity or
// request (retrying until the grant drops) and locks users after failed logins.
module user_session_monitor
    import user_session_monitor_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 1000,
    parameter int MAX_FAILS    = 3,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 ROM_access,
    input  logic [USER_ID_W-1:0] internal_id,
    input  logic                 red_led_user,
    input  logic                 activity,
    input  logic                 user_logout_req,
    input  logic                 admin_clear,
    output logic [NUM_USERS-1:0] status,
    output logic                 log_out,
    output logic                 session_active,
    output logic [USER_ID_W-1:0] session_id
);

    logic [1:0]                  state_q, state_d;
    logic                        rom_q, red_q, armed_q;
    logic                        log_out_q, log_out_d;
    logic                        session_active_q, session_active_d;
    logic [USER_ID_W-1:0]        session_id_q, session_id_d;
    logic [NUM_USERS-1:0]        status_q, status_d;
    logic [NUM_USERS-1:0][1:0]   fail_cnt_q, fail_cnt_d;

    logic                        rom_rise, red_rise, id_valid;
    logic                        idle_tc, ack_tc;
    logic                        idle_clear, idle_enable, ack_clear, ack_enable;
    logic [USER_ID_W-1:0]        user_bit;
    logic [1:0]                  inc_val;

    // armed_q masks the first sampled cycle so levels already high at reset
    // release are not mistaken for edges.
    assign rom_rise = armed_q && ROM_access && !rom_q;
    assign red_rise = armed_q && red_led_user && !red_q;
    assign id_valid = (internal_id != '0);
    assign user_bit = id_to_bit(internal_id);

    assign idle_clear  = (state_q != ST_ACTIVE) || activity;
    assign idle_enable = (state_q == ST_ACTIVE) && !activity;
    assign ack_clear   = (state_q != ST_LOGOUT) || ack_tc;
    assign ack_enable  = (state_q == ST_LOGOUT) && ROM_access;

    session_timeout_counter #(.LIMIT(IDLE_TIMEOUT)) u_idle_cnt (
        .clock  (clock),
        .rst    (rst),
        .clear  (idle_clear),
        .enable (idle_enable),
        .tc     (idle_tc)
    );

    session_timeout_counter #(.LIMIT(ACK_TIMEOUT)) u_ack_cnt (
        .clock  (clock),
        .rst    (rst),
        .clear  (ack_clear),
        .enable (ack_enable),
        .tc     (ack_tc)
    );

    always_comb begin
        state_d      = state_q;
        log_out_d    = 1'b0;
        session_id_d = session_id_q;
        case (state_q)
            ST_IDLE: begin
                if (rom_rise && id_valid) begin
                    state_d      = ST_ACTIVE;
                    session_id_d = internal_id;
                end
            end
            ST_ACTIVE: begin
                if (!ROM_access) begin
                    state_d      = ST_IDLE;
                    session_id_d = '0;
                end else if (user_logout_req || (!activity && idle_tc)) begin
                    state_d   = ST_LOGOUT;
                    log_out_d = 1'b1;
                end
            end
            ST_LOGOUT: begin
                if (!ROM_access) begin
                    state_d      = ST_IDLE;
                    session_id_d = '0;
                end else if (ack_tc) begin
                    log_out_d = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                session_id_d = '0;
            end
        endcase
        session_active_d = (state_d == ST_ACTIVE);
    end

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        status_d   = status_q;
        inc_val    = (fail_cnt_q[user_bit] == 2'b11) ? 2'b11 : fail_cnt_q[user_bit] + 2'd1;
        if (admin_clear) begin
            fail_cnt_d = '0;
            status_d   = '0;
        end else if ((state_q == ST_IDLE) && id_valid) begin
            if (red_rise) begin
                fail_cnt_d[user_bit] = inc_val;
                if (inc_val >= 2'(MAX_FAILS)) begin
                    status_d[user_bit] = 1'b1;
                end
            end
            // A successful login forgives earlier failures but not a lockout.
            if (rom_rise) begin
                fail_cnt_d[user_bit] = 2'b00;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            rom_q            <= 1'b0;
            red_q            <= 1'b0;
            armed_q          <= 1'b0;
            log_out_q        <= 1'b0;
            session_active_q <= 1'b0;
            session_id_q     <= '0;
            status_q         <= '0;
            fail_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            rom_q            <= ROM_access;
            red_q            <= red_led_user;
            armed_q          <= 1'b1;
            log_out_q        <= log_out_d;
            session_active_q <= session_active_d;
            session_id_q     <= session_id_d;
            status_q         <= status_d;
            fail_cnt_q       <= fail_cnt_d;
        end
    end

    assign status         = status_q;
    assign log_out        = log_out_q;
    assign session_active = session_active_q;
    assign session_id     = session_id_q;

endmodule

// File: tb/tb_user_session_monitor.sv
// Directed bench for user_session_monitor with short timeouts (idle 8, ack 16);
// outputs are sampled 1 time unit after each rising clock edge.
module tb_user_session_monitor;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       ROM_access = 1'b0;
    logic [2:0] internal_id = 3'd0;
    logic       red_led_user = 1'b0;
    logic       activity = 1'b0;
    logic       user_logout_req = 1'b0;
    logic       admin_clear = 1'b0;
    logic [6:0] status;
    logic       log_out;
    logic       session_active;
    logic [2:0] session_id;

    int errors = 0;
    int checks = 0;

    user_session_monitor #(
        .IDLE_TIMEOUT (8),
        .MAX_FAILS    (3),
        .ACK_TIMEOUT  (16)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .ROM_access      (ROM_access),
        .internal_id     (internal_id),
        .red_led_user    (red_led_user),
        .activity        (activity),
        .user_logout_req (user_logout_req),
        .admin_clear     (admin_clear),
        .status          (status),
        .log_out         (log_out),
        .session_active  (session_active),
        .session_id      (session_id)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic red_pulse(input logic [2:0] id);
        internal_id  = id;
        red_led_user = 1'b1;
        tick(1);
        red_led_user = 1'b0;
        tick(1);
    endtask

    initial begin
        // Reset values
        tick(2);
        check("reset_status", {1'b0, status}, 8'h00);
        check("reset_log_out", {7'b0, log_out}, 8'h00);
        check("reset_active", {7'b0, session_active}, 8'h00);
        check("reset_id", {5'b0, session_id}, 8'h00);
        rst = 1'b1;
        tick(2);

        // Three failures lock user 3; the lockout appears right after the 3rd edge
        red_pulse(3'd3);
        red_pulse(3'd3);
        check("lock3_two_fails", {1'b0, status}, 8'h00);
        internal_id  = 3'd3;
        red_led_user = 1'b1;
        tick(1);
        check("lock3_third_fail", {1'b0, status}, 8'h04);
        red_led_user = 1'b0;
        tick(1);
        red_pulse(3'd3);
        check("lock3_fourth_fail", {1'b0, status}, 8'h04);

        // Failures with ID 0 are ignored
        red_pulse(3'd0);
        red_pulse(3'd0);
        red_pulse(3'd0);
        check("id0_ignored", {1'b0, status}, 8'h04);

        // Two failures for user 2, then a login clears the counter
        red_pulse(3'd2);
        red_pulse(3'd2);
        check("user2_two_fails", {1'b0, status}, 8'h04);
        internal_id = 3'd2;
        ROM_access  = 1'b1;
        tick(1);
        check("login2_active", {7'b0, session_active}, 8'h01);
        check("login2_id", {5'b0, session_id}, 8'h02);
        user_logout_req = 1'b1;
        tick(1);
        check("req_log_out", {7'b0, log_out}, 8'h01);
        check("req_inactive", {7'b0, session_active}, 8'h00);
        user_logout_req = 1'b0;
        ROM_access      = 1'b0;
        tick(1);
        check("req_pulse_end", {7'b0, log_out}, 8'h00);
        check("req_id_cleared", {5'b0, session_id}, 8'h00);
        red_pulse(3'd2);
        check("user2_not_locked", {1'b0, status}, 8'h04);

        // Inactivity timeout at 8 cycles, then ack retry after 16 more
        tick(1);
        internal_id = 3'd4;
        ROM_access  = 1'b1;
        tick(1);
        check("login4_active", {7'b0, session_active}, 8'h01);
        tick(7);
        check("timeout_not_yet", {7'b0, log_out}, 8'h00);
        tick(1);
        check("timeout_pulse", {7'b0, log_out}, 8'h01);
        tick(1);
        check("timeout_pulse_end", {7'b0, log_out}, 8'h00);
        tick(14);
        check("retry_not_yet", {7'b0, log_out}, 8'h00);
        tick(1);
        check("retry_pulse", {7'b0, log_out}, 8'h01);
        tick(1);
        check("retry_pulse_end", {7'b0, log_out}, 8'h00);
        ROM_access = 1'b0;
        tick(1);
        check("ack_idle_active", {7'b0, session_active}, 8'h00);
        check("ack_idle_id", {5'b0, session_id}, 8'h00);

        // Activity reloads the idle count; request coinciding with timeout gives one pulse
        tick(1);
        internal_id = 3'd5;
        ROM_access  = 1'b1;
        tick(1);
        check("login5_id", {5'b0, session_id}, 8'h05);
        tick(3);
        activity = 1'b1;
        tick(1);
        activity = 1'b0;
        tick(6);
        check("activity_reload", {7'b0, log_out}, 8'h00);
        tick(1);
        check("coincide_not_yet", {7'b0, log_out}, 8'h00);
        user_logout_req = 1'b1;
        tick(1);
        check("coincide_pulse", {7'b0, log_out}, 8'h01);
        user_logout_req = 1'b0;
        tick(1);
        check("coincide_single", {7'b0, log_out}, 8'h00);
        ROM_access = 1'b0;
        tick(1);
        check("coincide_idle", {7'b0, session_active}, 8'h00);

        // Grant dropping mid-session returns to idle without a pulse
        internal_id = 3'd6;
        ROM_access  = 1'b1;
        tick(1);
        check("login6_active", {7'b0, session_active}, 8'h01);
        ROM_access = 1'b0;
        tick(1);
        check("drop_inactive", {7'b0, session_active}, 8'h00);
        check("drop_no_log_out", {7'b0, log_out}, 8'h00);
        check("drop_id", {5'b0, session_id}, 8'h00);

        // admin_clear wins over a coincident failure and clears every counter
        admin_clear = 1'b1;
        tick(1);
        admin_clear = 1'b0;
        check("admin_clear_status", {1'b0, status}, 8'h00);
        red_pulse(3'd2);
        red_pulse(3'd2);
        red_pulse(3'd2);
        check("lock2", {1'b0, status}, 8'h02);
        red_pulse(3'd5);
        red_pulse(3'd5);
        internal_id  = 3'd5;
        red_led_user = 1'b1;
        admin_clear  = 1'b1;
        tick(1);
        check("clear_priority", {1'b0, status}, 8'h00);
        red_led_user = 1'b0;
        admin_clear  = 1'b0;
        tick(1);
        red_pulse(3'd5);
        red_pulse(3'd5);
        check("user5_cnt_cleared", {1'b0, status}, 8'h00);
        red_pulse(3'd5);
        check("lock5", {1'b0, status}, 8'h10);
        red_pulse(3'd2);
        check("user2_cnt_cleared", {1'b0, status}, 8'h10);

        // Asynchronous reset mid-session
        internal_id = 3'd1;
        ROM_access  = 1'b1;
        tick(1);
        check("login1_active", {7'b0, session_active}, 8'h01);
        tick(2);
        #2;
        rst = 1'b0;
        #1;
        check("async_active", {7'b0, session_active}, 8'h00);
        check("async_id", {5'b0, session_id}, 8'h00);
        check("async_log_out", {7'b0, log_out}, 8'h00);
        check("async_status", {1'b0, status}, 8'h00);
        tick(2);
        check("held_rst_log_out", {7'b0, log_out}, 8'h00);
        rst = 1'b1;
        tick(3);
        check("held_grant_no_session", {7'b0, session_active}, 8'h00);
        check("held_grant_no_log_out", {7'b0, log_out}, 8'h00);
        ROM_access = 1'b0;
        tick(1);
        ROM_access = 1'b1;
        tick(1);
        check("relogin_active", {7'b0, session_active}, 8'h01);
        check("relogin_id", {5'b0, session_id}, 8'h01);
        ROM_access = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
